// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package mem_arb_pkg;

   localparam int DATA_W_DEF = 22;
   localparam int WAIT_W     = 16;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_HOST = 2'd2
   } owner_t;

endpackage

// File: rtl/data_mem_arbiter_burst_counter.sv
// Burst length counter for the arbiter: load-to-one, saturating increment, clear.
module arb_burst_counter #(
   parameter  int MAX_BURST = 8,
   localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_one,
   input  logic             incr,
   input  logic             clear,
   output logic [CNT_W-1:0] cnt,
   output logic             limit_hit
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (load_one) begin
         cnt <= CNT_ONE;
      end else if (incr && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_ONE;
      end
   end

   assign limit_hit = (cnt == CNT_MAX);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter (CPU, host) for the single-port data RAM with bounded
// burst ownership and tagged read return.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = 8,
   parameter int RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [DATA_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [DATA_W-1:0] host_adr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner,
   output logic [WAIT_W-1:0] wait_cnt
);

   if (RD_LAT != 1) begin : g_rd_lat_chk
      $error("data_mem_arbiter: only RD_LAT == 1 is supported");
   end
   if ((MAX_BURST < 1) || (MAX_BURST > 255)) begin : g_burst_chk
      $error("data_mem_arbiter: MAX_BURST must be in 1..255");
   end

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   owner_t           state_q;
   owner_t           state_d;
   logic             cpu_sel;
   logic             host_sel;
   logic             cnt_load;
   logic             cnt_incr;
   logic             cnt_clear;
   logic             limit_hit;
   logic [CNT_W-1:0] burst_cnt;
   logic             rd_tag_vld_p1;
   logic             rd_tag_host_p1;
   logic             wait_inc;

   arb_burst_counter #(
      .MAX_BURST (MAX_BURST)
   ) u_burst_counter (
      .clk       (clk),
      .rst       (rst),
      .load_one  (cnt_load),
      .incr      (cnt_incr),
      .clear     (cnt_clear),
      .cnt       (burst_cnt),
      .limit_hit (limit_hit)
   );

   // The owner keeps the port until its burst limit is reached while the
   // other side waits; an idle owner hands over in the same cycle.
   always_comb begin
      cpu_sel   = 1'b0;
      host_sel  = 1'b0;
      state_d   = OWN_NONE;
      cnt_load  = 1'b0;
      cnt_incr  = 1'b0;
      cnt_clear = 1'b0;
      case (state_q)
         OWN_CPU: begin
            if (cpu_req && (!limit_hit || !host_req)) begin
               cpu_sel  = 1'b1;
               state_d  = OWN_CPU;
               cnt_incr = 1'b1;
            end else if (host_req) begin
               host_sel = 1'b1;
               state_d  = OWN_HOST;
               cnt_load = 1'b1;
            end else begin
               cnt_clear = 1'b1;
            end
         end
         OWN_HOST: begin
            if (host_req && (!limit_hit || !cpu_req)) begin
               host_sel = 1'b1;
               state_d  = OWN_HOST;
               cnt_incr = 1'b1;
            end else if (cpu_req) begin
               cpu_sel  = 1'b1;
               state_d  = OWN_CPU;
               cnt_load = 1'b1;
            end else begin
               cnt_clear = 1'b1;
            end
         end
         default: begin
            if (cpu_req) begin
               cpu_sel  = 1'b1;
               state_d  = OWN_CPU;
               cnt_load = 1'b1;
            end else if (host_req) begin
               host_sel = 1'b1;
               state_d  = OWN_HOST;
               cnt_load = 1'b1;
            end else begin
               cnt_clear = 1'b1;
            end
         end
      endcase
      if (rst) begin
         cpu_sel  = 1'b0;
         host_sel = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OWN_NONE;
      end else begin
         state_q <= state_d;
      end
   end

   assign cpu_gnt   = cpu_sel;
   assign host_gnt  = host_sel;
   assign owner     = state_q;
   assign mem_we    = (cpu_sel & cpu_we) | (host_sel & host_we);
   assign mem_adr   = cpu_sel ? cpu_adr   : (host_sel ? host_adr   : '0);
   assign mem_wdata = cpu_sel ? cpu_wdata : (host_sel ? host_wdata : '0);

   // Read tag stage: remembers who issued the read accepted last cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_tag_vld_p1  <= 1'b0;
         rd_tag_host_p1 <= 1'b0;
      end else begin
         rd_tag_vld_p1  <= (cpu_sel & ~cpu_we) | (host_sel & ~host_we);
         rd_tag_host_p1 <= host_sel;
      end
   end

   assign cpu_rvalid  = rd_tag_vld_p1 & ~rd_tag_host_p1 & ~rst;
   assign host_rvalid = rd_tag_vld_p1 &  rd_tag_host_p1 & ~rst;
   assign rdata       = mem_rdata;

   assign wait_inc = (cpu_req & ~cpu_sel) | (host_req & ~host_sel);

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (wait_inc && (wait_cnt != {WAIT_W{1'b1}})) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_data_mem_arbiter;

   localparam int DATA_W    = 22;
   localparam int MAX_BURST = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_req = 1'b0;
   logic              cpu_we = 1'b0;
   logic [DATA_W-1:0] cpu_adr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic              cpu_gnt;
   logic              cpu_rvalid;
   logic              host_req = 1'b0;
   logic              host_we = 1'b0;
   logic [DATA_W-1:0] host_adr = '0;
   logic [DATA_W-1:0] host_wdata = '0;
   logic              host_gnt;
   logic              host_rvalid;
   logic [DATA_W-1:0] rdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_adr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [1:0]        owner;
   logic [15:0]       wait_cnt;

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] ram [0:63];

   always #5 clk = ~clk;

   data_mem_arbiter #(
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST),
      .RD_LAT    (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_adr     (cpu_adr),
      .cpu_wdata   (cpu_wdata),
      .cpu_gnt     (cpu_gnt),
      .cpu_rvalid  (cpu_rvalid),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_adr    (host_adr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt),
      .host_rvalid (host_rvalid),
      .rdata       (rdata),
      .mem_we      (mem_we),
      .mem_adr     (mem_adr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .owner       (owner),
      .wait_cnt    (wait_cnt)
   );

   always @(posedge clk) begin
      if (mem_we) ram[mem_adr[5:0]] <= mem_wdata;
      mem_rdata <= ram[mem_adr[5:0]];
   end

   // A requester must hold req until it is granted
   assert property (@(posedge clk) disable iff (rst) (cpu_req && !cpu_gnt) |=> cpu_req)
      else begin errors++; $display("FAIL cpu_req_held got 0 want 1 at %0t", $time); end
   assert property (@(posedge clk) disable iff (rst) (host_req && !host_gnt) |=> host_req)
      else begin errors++; $display("FAIL host_req_held got 0 want 1 at %0t", $time); end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
      host_req = 1'b0; host_we = 1'b0; host_adr = '0; host_wdata = '0;
      step;
      step;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 22'd3; cpu_wdata = 22'd11;
      host_req = 1'b1; host_we = 1'b1; host_adr = 22'd4; host_wdata = 22'd12;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({cpu_gnt, host_gnt} !== 2'b00)
            begin errors++; $display("FAIL rst_gnt got %b want 00", {cpu_gnt, host_gnt}); end
         checks++;
         if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
         checks++;
         if ((mem_adr !== '0) || (mem_wdata !== '0))
            begin errors++; $display("FAIL rst_mem_bus got %h/%h want 0/0", mem_adr, mem_wdata); end
         checks++;
         if (owner !== 2'd0) begin errors++; $display("FAIL rst_owner got %0d want 0", owner); end
         checks++;
         if (wait_cnt !== 16'd0) begin errors++; $display("FAIL rst_wait_cnt got %0d want 0", wait_cnt); end
         checks++;
         if ({cpu_rvalid, host_rvalid} !== 2'b00)
            begin errors++; $display("FAIL rst_rvalid got %b want 00", {cpu_rvalid, host_rvalid}); end
         step;
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({cpu_gnt, host_gnt} !== 2'b10)
         begin errors++; $display("FAIL rst_tiebreak_gnt got %b want 10", {cpu_gnt, host_gnt}); end
      checks++;
      if ((mem_we !== 1'b1) || (mem_adr !== 22'd3))
         begin errors++; $display("FAIL rst_tiebreak_mem got we=%b adr=%h want we=1 adr=3", mem_we, mem_adr); end
      step;
      @(negedge clk);
      checks++;
      if ((owner !== 2'd1) || (wait_cnt !== 16'd1))
         begin errors++; $display("FAIL rst_after_owner got %0d/%0d want 1/1", owner, wait_cnt); end
   endtask

   task automatic test_cpu_only;
      apply_reset;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 22'd5; cpu_wdata = 22'h3ABCD;
      @(negedge clk);
      checks++;
      if ({cpu_gnt, host_gnt, mem_we} !== 3'b101)
         begin errors++; $display("FAIL cpu_wr_gnt got gnt=%b%b we=%b want 1 0 1", cpu_gnt, host_gnt, mem_we); end
      checks++;
      if ((mem_adr !== 22'd5) || (mem_wdata !== 22'h3ABCD))
         begin errors++; $display("FAIL cpu_wr_bus got %h/%h want 5/3abcd", mem_adr, mem_wdata); end
      step;
      cpu_we = 1'b0;
      @(negedge clk);
      checks++;
      if ({cpu_gnt, mem_we, cpu_rvalid} !== 3'b100)
         begin errors++; $display("FAIL cpu_rd_gnt got gnt=%b we=%b rv=%b want 1 0 0", cpu_gnt, mem_we, cpu_rvalid); end
      step;
      cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({cpu_rvalid, host_rvalid} !== 2'b10)
         begin errors++; $display("FAIL cpu_rd_rvalid got %b want 10", {cpu_rvalid, host_rvalid}); end
      checks++;
      if (rdata !== 22'h3ABCD) begin errors++; $display("FAIL cpu_rd_data got %h want 3abcd", rdata); end
      checks++;
      if (owner !== 2'd1) begin errors++; $display("FAIL cpu_owner got %0d want 1", owner); end
      step;
      @(negedge clk);
      checks++;
      if ({cpu_rvalid, host_rvalid, owner} !== 4'b0000)
         begin errors++; $display("FAIL cpu_idle got rv=%b%b owner=%0d want 00 0", cpu_rvalid, host_rvalid, owner); end
   endtask

   task automatic test_fairness;
      logic prev_c;
      logic prev_h;
      apply_reset;
      cpu_req = 1'b1; cpu_adr = 22'd10;
      host_req = 1'b1; host_adr = 22'd20;
      prev_c = 1'b0;
      prev_h = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         logic exp_c;
         logic exp_h;
         exp_c = (k <= MAX_BURST) || (k == 2 * MAX_BURST + 1);
         exp_h = (k > MAX_BURST) && (k <= 2 * MAX_BURST);
         @(negedge clk);
         checks++;
         if ({cpu_gnt, host_gnt} !== {exp_c, exp_h})
            begin errors++; $display("FAIL fair_gnt cycle %0d got %b want %b", k, {cpu_gnt, host_gnt}, {exp_c, exp_h}); end
         checks++;
         if (mem_adr !== (exp_c ? 22'd10 : 22'd20))
            begin errors++; $display("FAIL fair_adr cycle %0d got %h want %h", k, mem_adr, exp_c ? 22'd10 : 22'd20); end
         checks++;
         if (wait_cnt !== 16'(k - 1))
            begin errors++; $display("FAIL fair_wait cycle %0d got %0d want %0d", k, wait_cnt, k - 1); end
         checks++;
         if ({cpu_rvalid, host_rvalid} !== {prev_c, prev_h})
            begin errors++; $display("FAIL fair_rvalid cycle %0d got %b want %b", k, {cpu_rvalid, host_rvalid}, {prev_c, prev_h}); end
         prev_c = exp_c;
         prev_h = exp_h;
         step;
      end
   endtask

   task automatic test_saturate;
      apply_reset;
      cpu_req = 1'b1; cpu_adr = 22'd30;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL sat_cpu_gnt cycle %0d got %b want 1", k, cpu_gnt); end
         step;
      end
      host_req = 1'b1; host_adr = 22'd31;
      @(negedge clk);
      checks++;
      if ({cpu_gnt, host_gnt} !== 2'b01)
         begin errors++; $display("FAIL sat_handover got %b want 01", {cpu_gnt, host_gnt}); end
      step;
      @(negedge clk);
      checks++;
      if ((owner !== 2'd2) || ({cpu_gnt, host_gnt} !== 2'b01))
         begin errors++; $display("FAIL sat_host_own got owner=%0d gnt=%b want 2 01", owner, {cpu_gnt, host_gnt}); end
   endtask

   task automatic test_release;
      apply_reset;
      cpu_req = 1'b1; cpu_adr = 22'd40;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (cpu_gnt !== 1'b1) begin errors++; $display("FAIL rel_cpu_gnt cycle %0d got %b want 1", k, cpu_gnt); end
         step;
      end
      cpu_req = 1'b0;
      host_req = 1'b1; host_we = 1'b1; host_adr = 22'd7; host_wdata = 22'h155;
      @(negedge clk);
      checks++;
      if ({cpu_gnt, host_gnt} !== 2'b01)
         begin errors++; $display("FAIL rel_host_gnt got %b want 01", {cpu_gnt, host_gnt}); end
      checks++;
      if ((mem_we !== 1'b1) || (mem_adr !== 22'd7) || (mem_wdata !== 22'h155))
         begin errors++; $display("FAIL rel_host_bus got we=%b adr=%h wd=%h want 1 7 155", mem_we, mem_adr, mem_wdata); end
      step;
      host_req = 1'b0; host_we = 1'b0;
      @(negedge clk);
      checks++;
      if (owner !== 2'd2) begin errors++; $display("FAIL rel_owner_host got %0d want 2", owner); end
      checks++;
      if ((mem_we !== 1'b0) || (mem_adr !== '0) || (host_rvalid !== 1'b0))
         begin errors++; $display("FAIL rel_idle_bus got we=%b adr=%h rv=%b want 0 0 0", mem_we, mem_adr, host_rvalid); end
      step;
      @(negedge clk);
      checks++;
      if (owner !== 2'd0) begin errors++; $display("FAIL rel_owner_none got %0d want 0", owner); end
   endtask

   task automatic test_interleave;
      apply_reset;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 22'd1; cpu_wdata = 22'd7;
      step;
      cpu_req = 1'b0; cpu_we = 1'b0;
      host_req = 1'b1; host_we = 1'b1; host_adr = 22'd2; host_wdata = 22'd9;
      step;
      host_req = 1'b0; host_we = 1'b0;
      cpu_req = 1'b1; cpu_adr = 22'd1;
      @(negedge clk);
      checks++;
      if ({cpu_gnt, host_gnt} !== 2'b10)
         begin errors++; $display("FAIL il_cpu_rd_gnt got %b want 10", {cpu_gnt, host_gnt}); end
      step;
      cpu_req = 1'b0;
      host_req = 1'b1; host_adr = 22'd2;
      @(negedge clk);
      checks++;
      if ({cpu_gnt, host_gnt} !== 2'b01)
         begin errors++; $display("FAIL il_host_rd_gnt got %b want 01", {cpu_gnt, host_gnt}); end
      checks++;
      if (({cpu_rvalid, host_rvalid} !== 2'b10) || (rdata !== 22'd7))
         begin errors++; $display("FAIL il_cpu_ret got rv=%b data=%0d want 10 7", {cpu_rvalid, host_rvalid}, rdata); end
      step;
      host_req = 1'b0;
      @(negedge clk);
      checks++;
      if (({cpu_rvalid, host_rvalid} !== 2'b01) || (rdata !== 22'd9))
         begin errors++; $display("FAIL il_host_ret got rv=%b data=%0d want 01 9", {cpu_rvalid, host_rvalid}, rdata); end
      step;
      @(negedge clk);
      checks++;
      if ({cpu_rvalid, host_rvalid} !== 2'b00)
         begin errors++; $display("FAIL il_quiet got %b want 00", {cpu_rvalid, host_rvalid}); end
   endtask

   task automatic test_reset_mid_read;
      apply_reset;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 22'd5;
      host_req = 1'b1; host_we = 1'b0; host_adr = 22'd2;
      @(negedge clk);
      checks++;
      if ({cpu_gnt, host_gnt} !== 2'b10)
         begin errors++; $display("FAIL mid_gnt got %b want 10", {cpu_gnt, host_gnt}); end
      step;
      rst = 1'b1;
      cpu_req = 1'b0; host_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({cpu_rvalid, host_rvalid} !== 2'b00)
         begin errors++; $display("FAIL mid_rst_rvalid got %b want 00", {cpu_rvalid, host_rvalid}); end
      step;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({cpu_rvalid, host_rvalid} !== 2'b00)
         begin errors++; $display("FAIL mid_after_rvalid got %b want 00", {cpu_rvalid, host_rvalid}); end
      checks++;
      if ((owner !== 2'd0) || (wait_cnt !== 16'd0))
         begin errors++; $display("FAIL mid_after_state got owner=%0d wait=%0d want 0 0", owner, wait_cnt); end
   endtask

   initial begin
      test_reset;
      test_cpu_only;
      test_fairness;
      test_saturate;
      test_release;
      test_interleave;
      test_reset_mid_read;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
